// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in/serial-out transmitter with valid/ready word intake
module piso_shift_tx #(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] datin,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             datout,
    output logic             dout_valid,
    output logic             frame_end
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    logic [0:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] sr, src, nxt;
    logic             last, accept, head;
    // The shift register only holds bits still to be sent; head is the bit put on datout next edge
    always_comb begin
        last      = (state == SHIFT) && (count == LAST);
        din_ready = (state == IDLE) || last;
        accept    = din_valid && din_ready;
        src       = accept ? datin : sr;
        head      = MSB_FIRST ? src[WIDTH-1] : src[0];
        nxt       = MSB_FIRST ? src << 1 : src >> 1;
    end
    // Load on accept, shift while mid-frame, otherwise fall back to idle
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sr         <= '0;
            count      <= '0;
            datout     <= IDLE_LEVEL;
            dout_valid <= 1'b0;
            frame_end  <= 1'b0;
        end else if (accept) begin
            state      <= SHIFT;
            sr         <= nxt;
            count      <= '0;
            datout     <= head;
            dout_valid <= 1'b1;
            frame_end  <= (LAST == '0);
        end else if (state == SHIFT && !last) begin
            sr         <= nxt;
            count      <= count + CW'(1);
            datout     <= head;
            frame_end  <= (count + CW'(1) == LAST);
        end else begin
            state      <= IDLE;
            count      <= '0;
            datout     <= IDLE_LEVEL;
            dout_valid <= 1'b0;
            frame_end  <= 1'b0;
        end
    end
endmodule
